i2c_line_filter: RTL and testbench

Front-end conditioning stage for the logic analyzer's I2C path. Synchronizes raw SCL/SDA pins into `clk`, rejects pulses shorter than a programmable stability window, and emits clean levels, single-cycle edge strobes and START/STOP strobes to the downstream I2C decoder. Rejected pulses are reported as glitch events and counted for the host status readout.

---
 rtl/i2c_line_filter.sv | 191 +++++++++++++++++++
 tb/tb_i2c_line_filter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_filter.sv
// I2C pin conditioning: synchronizes SCL/SDA, rejects short pulses and
// produces clean levels, edge strobes, START/STOP strobes and glitch status.
module i2c_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             filter_en,
    input  logic             clr_glitch,
    output logic             scl_out,
    output logic             sda_out,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             sda_rise,
    output logic             sda_fall,
    output logic             start_det,
    output logic             stop_det,
    output logic             glitch,
    output logic [1:0]       glitch_line,
    output logic [CNT_W-1:0] glitch_count,
    output logic             glitch_sticky
);

    localparam int unsigned NUM_LINES = 2;
    localparam int unsigned PEND_W    = 4;
    localparam int unsigned SUM_W     = CNT_W + 1;

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [PEND_W-1:0] PEND_LAST = PEND_W'(FILTER_LEN - 1);

    // Line index 0 = SCL, 1 = SDA
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [NUM_LINES-1:0]   samp;

    logic [0:0]        state_q [NUM_LINES];
    logic [0:0]        state_d [NUM_LINES];
    logic [PEND_W-1:0] pend_q  [NUM_LINES];
    logic [PEND_W-1:0] pend_d  [NUM_LINES];

    logic [NUM_LINES-1:0] out_q, out_d;
    logic [NUM_LINES-1:0] rise_q, rise_d;
    logic [NUM_LINES-1:0] fall_q, fall_d;
    logic [NUM_LINES-1:0] glitch_line_q, glitch_line_d;

    logic             scl_prev_q;
    logic             glitch_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       glitch_inc;
    logic [SUM_W-1:0] count_sum;

    // Metastability synchronizers, reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign samp = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};

    // Filter state registers for both lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]    <= ST_STABLE;
            state_q[1]    <= ST_STABLE;
            pend_q[0]     <= '0;
            pend_q[1]     <= '0;
            out_q         <= '1;
            rise_q        <= '0;
            fall_q        <= '0;
            glitch_line_q <= '0;
        end else begin
            state_q[0]    <= state_d[0];
            state_q[1]    <= state_d[1];
            pend_q[0]     <= pend_d[0];
            pend_q[1]     <= pend_d[1];
            out_q         <= out_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            glitch_line_q <= glitch_line_d;
        end
    end

    // Per-line stability filter: a new level must persist FILTER_LEN samples
    always_comb begin
        out_d         = out_q;
        rise_d        = '0;
        fall_d        = '0;
        glitch_line_d = '0;
        for (int l = 0; l < NUM_LINES; l++) begin
            state_d[l] = state_q[l];
            pend_d[l]  = pend_q[l];
            if (!filter_en) begin
                // Bypass follows the synchronized level and abandons any pending change
                state_d[l] = ST_STABLE;
                pend_d[l]  = '0;
                out_d[l]   = samp[l];
                rise_d[l]  = samp[l] & ~out_q[l];
                fall_d[l]  = ~samp[l] & out_q[l];
            end else begin
                case (state_q[l])
                    ST_STABLE: begin
                        if (samp[l] != out_q[l]) begin
                            state_d[l] = ST_PENDING;
                            pend_d[l]  = PEND_W'(1);
                        end
                    end
                    ST_PENDING: begin
                        if (samp[l] == out_q[l]) begin
                            state_d[l]       = ST_STABLE;
                            pend_d[l]        = '0;
                            glitch_line_d[l] = 1'b1;
                        end else if (pend_q[l] == PEND_LAST) begin
                            state_d[l] = ST_STABLE;
                            pend_d[l]  = '0;
                            out_d[l]   = samp[l];
                            rise_d[l]  = samp[l];
                            fall_d[l]  = ~samp[l];
                        end else begin
                            pend_d[l] = pend_q[l] + PEND_W'(1);
                        end
                    end
                    default: begin
                        state_d[l] = ST_STABLE;
                        pend_d[l]  = '0;
                    end
                endcase
            end
        end
    end

    assign glitch_inc = {1'b0, glitch_line_d[0]} + {1'b0, glitch_line_d[1]};
    assign count_sum  = {1'b0, count_q} + SUM_W'(glitch_inc);

    // Saturating glitch counter and sticky flag; clear wins but keeps this cycle's glitches
    always_comb begin
        count_d  = count_q;
        sticky_d = sticky_q;
        if (clr_glitch) begin
            count_d  = CNT_W'(glitch_inc);
            sticky_d = |glitch_line_d;
        end else begin
            if (count_sum[CNT_W]) begin
                count_d = '1;
            end else begin
                count_d = count_sum[CNT_W-1:0];
            end
            sticky_d = sticky_q | (|glitch_line_d);
        end
    end

    // Glitch status registers and the pre-update SCL level for START/STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            glitch_q   <= 1'b0;
            count_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            scl_prev_q <= out_q[0];
            glitch_q   <= |glitch_line_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
        end
    end

    assign scl_out       = out_q[0];
    assign sda_out       = out_q[1];
    assign scl_rise      = rise_q[0];
    assign scl_fall      = fall_q[0];
    assign sda_rise      = rise_q[1];
    assign sda_fall      = fall_q[1];
    assign start_det     = fall_q[1] & scl_prev_q;
    assign stop_det      = rise_q[1] & scl_prev_q;
    assign glitch        = glitch_q;
    assign glitch_line   = glitch_line_q;
    assign glitch_count  = count_q;
    assign glitch_sticky = sticky_q;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Bench for i2c_line_filter: directed scenarios plus random pin activity,
// checked every cycle against a run-length reference model.
module tb_i2c_line_filter;

    localparam int SYNC    = 2;
    localparam int FLEN    = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [19:0] RESET_VEC = {2'b11, 18'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic filter_en = 1'b1;
    logic clr_glitch = 1'b0;

    logic          scl_out, sda_out, scl_rise, scl_fall, sda_rise, sda_fall;
    logic          start_det, stop_det, glitch, glitch_sticky;
    logic [1:0]    glitch_line;
    logic [CW-1:0] glitch_count;

    int n_checks = 0;
    int n_errors = 0;

    i2c_line_filter #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FLEN),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .filter_en    (filter_en),
        .clr_glitch   (clr_glitch),
        .scl_out      (scl_out),
        .sda_out      (sda_out),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .sda_rise     (sda_rise),
        .sda_fall     (sda_fall),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .glitch       (glitch),
        .glitch_line  (glitch_line),
        .glitch_count (glitch_count),
        .glitch_sticky(glitch_sticky)
    );

    always #5 clk = ~clk;

    // Reference model: pins delayed SYNC cycles, then a level is accepted once
    // FLEN consecutive samples differ from the output; a shorter run is a glitch.
    bit [1:0] m_o = 2'b11;
    bit [1:0] m_rise, m_fall, m_gl;
    bit       m_start, m_stop, m_glitch, m_sticky;
    int       m_cnt;
    int       m_run [2];
    bit       m_pipe [2][SYNC];

    always @(posedge clk or negedge rst_n) begin : model
        bit s;
        bit pin;
        bit prev_scl;
        int inc;
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                for (int k = 0; k < SYNC; k++) m_pipe[l][k] = 1'b1;
                m_run[l] = 0;
            end
            m_o = 2'b11; m_rise = 2'b00; m_fall = 2'b00; m_gl = 2'b00;
            m_start = 0; m_stop = 0; m_glitch = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            prev_scl = m_o[0];
            for (int l = 0; l < 2; l++) begin
                pin = (l == 0) ? scl_in : sda_in;
                s = m_pipe[l][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_pipe[l][k] = m_pipe[l][k-1];
                m_pipe[l][0] = pin;
                m_rise[l] = 0; m_fall[l] = 0; m_gl[l] = 0;
                if (!filter_en) begin
                    m_run[l] = 0;
                    if (s != m_o[l]) begin
                        m_rise[l] = s; m_fall[l] = !s; m_o[l] = s;
                    end
                end else if (s != m_o[l]) begin
                    m_run[l] = m_run[l] + 1;
                    if (m_run[l] == FLEN) begin
                        m_rise[l] = s; m_fall[l] = !s; m_o[l] = s; m_run[l] = 0;
                    end
                end else begin
                    m_gl[l] = (m_run[l] > 0);
                    m_run[l] = 0;
                end
            end
            m_start = m_fall[1] & prev_scl;
            m_stop  = m_rise[1] & prev_scl;
            inc = int'(m_gl[0]) + int'(m_gl[1]);
            m_glitch = (inc > 0);
            if (clr_glitch) begin
                m_cnt = inc;
                m_sticky = (inc > 0);
            end else begin
                m_cnt = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
                m_sticky = m_sticky | (inc > 0);
            end
        end
    end

    logic [19:0] dut_vec, exp_vec;
    assign dut_vec = {scl_out, sda_out, scl_rise, scl_fall, sda_rise, sda_fall,
                      start_det, stop_det, glitch, glitch_line, glitch_sticky, glitch_count};
    assign exp_vec = {m_o[0], m_o[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1],
                      m_start, m_stop, m_glitch, m_gl[1], m_gl[0], m_sticky, CW'(m_cnt)};

    task automatic test_reset();
        rst_n = 1'b0; scl_in = 1'b1; sda_in = 1'b1; filter_en = 1'b1; clr_glitch = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== RESET_VEC) begin
                n_errors++; $display("FAIL reset_hold got %h exp %h", dut_vec, RESET_VEC);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== RESET_VEC || dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL reset_idle cyc %0d got %h exp %h", c, dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_clean_edge();
        int lat;
        bit strobe_ok;
        for (int phase = 0; phase < 2; phase++) begin
            lat = -1;
            strobe_ok = 1'b1;
            for (int c = 0; c < 10; c++) begin
                sda_in = (phase == 1);
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL clean_edge_model got %h exp %h", dut_vec, exp_vec);
                end
                if (phase == 0 && sda_fall && lat < 0) begin lat = c + 1; strobe_ok = start_det; end
                if (phase == 1 && sda_rise && lat < 0) begin lat = c + 1; strobe_ok = stop_det; end
            end
            n_checks++;
            if (lat !== SYNC + FLEN || strobe_ok !== 1'b1) begin
                n_errors++;
                $display("FAIL clean_edge_latency phase %0d got edge %0d start/stop %0b exp edge %0d 1",
                         phase, lat, strobe_ok, SYNC + FLEN);
            end
        end
    endtask

    task automatic test_glitch_reject();
        int widths [3]  = '{2, 3, 4};
        bit exp_fall [3] = '{1'b0, 1'b0, 1'b1};
        int exp_cnt [3] = '{1, 2, 2};
        bit saw_fall, saw_gl;
        for (int t = 0; t < 3; t++) begin
            saw_fall = 0; saw_gl = 0;
            for (int c = 0; c < widths[t] + 10; c++) begin
                scl_in = (c >= widths[t]);
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL glitch_model w%0d got %h exp %h", widths[t], dut_vec, exp_vec);
                end
                if (scl_fall) saw_fall = 1;
                if (glitch && glitch_line == 2'b01) saw_gl = 1;
            end
            n_checks++;
            if (saw_fall !== exp_fall[t] || saw_gl !== !exp_fall[t] ||
                glitch_count !== CW'(exp_cnt[t]) || glitch_sticky !== 1'b1) begin
                n_errors++;
                $display("FAIL glitch_width%0d got fall %0b gl %0b cnt %0d sticky %0b exp fall %0b gl %0b cnt %0d sticky 1",
                         widths[t], saw_fall, saw_gl, glitch_count, glitch_sticky,
                         exp_fall[t], !exp_fall[t], exp_cnt[t]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit saw_both = 0;
        for (int c = 0; c < 10; c++) begin
            scl_in = (c != 0); sda_in = (c != 0);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL simul_model got %h exp %h", dut_vec, exp_vec);
            end
            if (glitch && glitch_line == 2'b11) saw_both = 1;
        end
        n_checks++;
        if (saw_both !== 1'b1 || glitch_count !== CW'(4)) begin
            n_errors++; $display("FAIL simul_glitch got both %0b cnt %0d exp 1 4", saw_both, glitch_count);
        end
    endtask

    task automatic test_clear_collision();
        clr_glitch = 1'b1;
        @(negedge clk);
        clr_glitch = 1'b0;
        n_checks++;
        if (glitch_count !== '0 || glitch_sticky !== 1'b0 || dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL clear_plain got cnt %0d sticky %0b exp 0 0", glitch_count, glitch_sticky);
        end
        // Build count to 5: two double glitches and one SCL glitch
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 8; c++) begin
                scl_in = (c != 0); sda_in = (c != 0) || (p == 2);
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL clear_build got %h exp %h", dut_vec, exp_vec);
                end
            end
        end
        n_checks++;
        if (glitch_count !== CW'(5)) begin
            n_errors++; $display("FAIL clear_prefill got %0d exp 5", glitch_count);
        end
        // SDA one-sample pulse; its glitch registers on edge 4 together with the clear
        for (int c = 0; c < 4; c++) begin
            sda_in = (c != 0);
            clr_glitch = (c == 3);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL clear_collide_model got %h exp %h", dut_vec, exp_vec);
            end
        end
        clr_glitch = 1'b0;
        n_checks++;
        if (glitch_count !== CW'(1) || glitch_sticky !== 1'b1 || glitch_line !== 2'b10) begin
            n_errors++;
            $display("FAIL clear_collide got cnt %0d sticky %0b line %b exp 1 1 10",
                     glitch_count, glitch_sticky, glitch_line);
        end
    endtask

    task automatic test_saturation();
        clr_glitch = 1'b1;
        @(negedge clk);
        clr_glitch = 1'b0;
        for (int p = 0; p < 129; p++) begin
            for (int c = 0; c < 6; c++) begin
                scl_in = (c != 0); sda_in = (c != 0);
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL sat_model p%0d got %h exp %h", p, dut_vec, exp_vec);
                end
            end
            if (p == 126 || p == 127 || p == 128) begin
                n_checks++;
                if (glitch_count !== ((p == 126) ? CW'(254) : CW'(CNT_MAX))) begin
                    n_errors++; $display("FAIL sat_count p%0d got %0d exp %0d", p, glitch_count,
                                         (p == 126) ? 254 : CNT_MAX);
                end
            end
        end
    endtask

    task automatic test_bypass();
        int fall_at = -1;
        int rise_at = -1;
        bit saw_bad = 0;
        filter_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sda_in = (c != 0);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL bypass_model got %h exp %h", dut_vec, exp_vec);
            end
            if (sda_fall && fall_at < 0) fall_at = c + 1;
            if (sda_rise && rise_at < 0) rise_at = c + 1;
            if (glitch) saw_bad = 1;
        end
        n_checks++;
        if (fall_at !== SYNC + 1 || rise_at !== SYNC + 2 || saw_bad !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_pulse got fall %0d rise %0d glitch %0b exp %0d %0d 0",
                     fall_at, rise_at, saw_bad, SYNC + 1, SYNC + 2);
        end
        // Drop the filter while a pulse is pending, then re-enable
        filter_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            sda_in = (c != 0);
            filter_en = (c < 3) || (c >= 10);
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL bypass_midpend_model got %h exp %h", dut_vec, exp_vec);
            end
            if (glitch || sda_fall || sda_rise || sda_out !== 1'b1) saw_bad = 1;
        end
        n_checks++;
        if (saw_bad !== 1'b0) begin
            n_errors++; $display("FAIL bypass_midpend got glitch/strobe %0b exp 0", saw_bad);
        end
    endtask

    task automatic test_reset_mid_pending();
        for (int c = 0; c < 3; c++) begin
            scl_in = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        scl_in = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC || dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL reset_midpend got %h exp %h", dut_vec, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== RESET_VEC) begin
                n_errors++; $display("FAIL reset_midpend_after got %h exp %h", dut_vec, RESET_VEC);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 300; seg++) begin
            scl_in = 1'($urandom_range(0, 1));
            sda_in = 1'($urandom_range(0, 1));
            clr_glitch = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) filter_en = !filter_en;
            len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                clr_glitch = 1'b0;
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL random seg %0d got %h exp %h", seg, dut_vec, exp_vec);
                end
            end
        end
        scl_in = 1'b1; sda_in = 1'b1; filter_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL random_tail got %h exp %h", dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch_reject();
        test_simultaneous();
        test_clear_collision();
        test_saturation();
        test_bypass();
        test_reset_mid_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
